// File: rtl/mmio_timer_pkg.sv
// Shared register map and bit positions for the mmio_timer block.
package mmio_timer_pkg;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_LOAD   = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_AUTO_BIT  = 1;
  localparam int CTRL_IE_BIT    = 2;
  localparam int STATUS_EXP_BIT = 0;

  typedef struct packed {
    logic ie;
    logic auto_rl;
    logic en;
  } ctrl_t;

  // Packs the control fields into their bus-visible word; unused bits read 0.
  function automatic logic [31:0] ctrl_word(input ctrl_t c);
    logic [31:0] w;
    w                = '0;
    w[CTRL_EN_BIT]   = c.en;
    w[CTRL_AUTO_BIT] = c.auto_rl;
    w[CTRL_IE_BIT]   = c.ie;
    return w;
  endfunction

endpackage

// File: rtl/mmio_prescaler.sv
// Clock prescaler: counts 0..PRESCALE-1 while enabled, one tick per wrap.
// Held at 0 while disabled or when restarted.
module mmio_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic restart,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  // Tick is combinational on the last phase so the timer acts on the same edge as the wrap.
  assign tick = en && (cnt == LAST);

  // Phase counter, cleared by restart or while disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (restart || !en || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + PW'(1);
    end
  end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped down-counting timer with reload, expiry flag and optional irq.
// Optional feature: define MMIO_TIMER_IRQ_EN to enable CTRL.IE and the irq output;
// otherwise irq is tied low and CTRL.IE reads 0.
module mmio_timer
  import mmio_timer_pkg::*;
#(
  parameter int PRESCALE = 1,
  parameter int WIDTH    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rvalid,
  output logic        irq
);

  ctrl_t            ctrl_q, ctrl_d;
  logic [WIDTH-1:0] load_q, load_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             exp_q, exp_d;
  logic             expire;
  logic             tick;
  logic [31:0]      load_ext, count_ext, rd_word;

  logic wr_ctrl, wr_load, wr_status, rd_req;
  logic unused_wdata;

  assign wr_ctrl   = sel && we && (addr == ADDR_CTRL);
  assign wr_load   = sel && we && (addr == ADDR_LOAD);
  assign wr_status = sel && we && (addr == ADDR_STATUS);
  assign rd_req    = sel && !we;

  // Upper write-data bits are ignored for narrow counters and CTRL/STATUS.
  assign unused_wdata = ^wdata;

  mmio_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk    (clk),
    .reset  (reset),
    .en     (ctrl_q.en),
    .restart(wr_load),
    .tick   (tick)
  );

  // Next-state for the register file: LOAD beats a tick, expiry beats an EXP clear,
  // a CTRL write overrides the expiry's EN clear.
  always_comb begin
    ctrl_d  = ctrl_q;
    load_d  = load_q;
    count_d = count_q;
    exp_d   = exp_q;
    expire  = 1'b0;
    if (wr_load) begin
      load_d  = wdata[WIDTH-1:0];
      count_d = wdata[WIDTH-1:0];
    end else if (tick) begin
      if (count_q != '0) begin
        count_d = count_q - WIDTH'(1);
      end else begin
        expire = 1'b1;
        if (ctrl_q.auto_rl) begin
          count_d = load_q;
        end else begin
          ctrl_d.en = 1'b0;
        end
      end
    end
    if (wr_ctrl) begin
      ctrl_d.en      = wdata[CTRL_EN_BIT];
      ctrl_d.auto_rl = wdata[CTRL_AUTO_BIT];
`ifdef MMIO_TIMER_IRQ_EN
      ctrl_d.ie      = wdata[CTRL_IE_BIT];
`else
      ctrl_d.ie      = 1'b0;
`endif
    end
    if (wr_status && wdata[STATUS_EXP_BIT]) begin
      exp_d = 1'b0;
    end
    if (expire) begin
      exp_d = 1'b1;
    end
  end

  // Zero-extend the WIDTH-wide registers onto the 32-bit read bus.
  always_comb begin
    load_ext              = '0;
    count_ext             = '0;
    load_ext[WIDTH-1:0]   = load_q;
    count_ext[WIDTH-1:0]  = count_q;
  end

  // Read-data mux over the four word offsets.
  always_comb begin
    rd_word = '0;
    case (addr)
      ADDR_CTRL:   rd_word = ctrl_word(ctrl_q);
      ADDR_LOAD:   rd_word = load_ext;
      ADDR_COUNT:  rd_word = count_ext;
      ADDR_STATUS: rd_word[STATUS_EXP_BIT] = exp_q;
      default:     rd_word = '0;
    endcase
  end

  // Register file state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q  <= '0;
      load_q  <= '0;
      count_q <= '0;
      exp_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      load_q  <= load_d;
      count_q <= count_d;
      exp_q   <= exp_d;
    end
  end

  // Registered read port: rdata holds between reads, rvalid pulses for one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= rd_req;
      if (rd_req) begin
        rdata <= rd_word;
      end
    end
  end

`ifdef MMIO_TIMER_IRQ_EN
  // irq follows the next-state EXP and IE so it rises on the same edge as EXP.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq <= 1'b0;
    end else begin
      irq <= exp_d && ctrl_d.ie;
    end
  end
`else
  assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: one instance with PRESCALE=1, one with PRESCALE=4.
module tb_mmio_timer;
  import mmio_timer_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        sel1, sel4, we;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata1, rdata4;
  logic        rvalid1, rvalid4, irq1, irq4;

  int n_tests = 0;
  int n_fail  = 0;

`ifdef MMIO_TIMER_IRQ_EN
  localparam logic [31:0] IRQ_EXP  = 32'd1;
  localparam logic [31:0] CTRL7_RD = 32'h7;
`else
  localparam logic [31:0] IRQ_EXP  = 32'd0;
  localparam logic [31:0] CTRL7_RD = 32'h3;
`endif

  mmio_timer #(.PRESCALE(1), .WIDTH(32)) u_p1 (
    .clk(clk), .reset(rst_n), .sel(sel1), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata1), .rvalid(rvalid1), .irq(irq1)
  );

  mmio_timer #(.PRESCALE(4), .WIDTH(16)) u_p4 (
    .clk(clk), .reset(rst_n), .sel(sel4), .we(we), .addr(addr), .wdata(wdata),
    .rdata(rdata4), .rvalid(rvalid4), .irq(irq4)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic wr(input int which, input logic [1:0] a, input logic [31:0] d);
    if (which == 1) sel1 = 1'b1; else sel4 = 1'b1;
    we = 1'b1; addr = a; wdata = d;
    @(posedge clk); #1;
    sel1 = 1'b0; sel4 = 1'b0; we = 1'b0;
  endtask

  task automatic rd_chk(input int which, input logic [1:0] a, input logic [31:0] exp,
                        input string tag);
    if (which == 1) sel1 = 1'b1; else sel4 = 1'b1;
    we = 1'b0; addr = a;
    @(posedge clk); #1;
    sel1 = 1'b0; sel4 = 1'b0;
    check_eq({tag, "_rvalid"}, (which == 1) ? {31'b0, rvalid1} : {31'b0, rvalid4}, 32'd1);
    check_eq(tag, (which == 1) ? rdata1 : rdata4, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    clk = 1'b0; rst_n = 1'b0;
    sel1 = 1'b0; sel4 = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    #3;
    check_eq("rst_rdata1", rdata1, 32'd0);
    check_eq("rst_rvalid1", {31'b0, rvalid1}, 32'd0);
    check_eq("rst_irq1", {31'b0, irq1}, 32'd0);
    check_eq("rst_rdata4", rdata4, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // One-shot countdown with PRESCALE=1.
    wr(1, ADDR_LOAD, 32'd3);
    wr(1, ADDR_CTRL, 32'h1);
    rd_chk(1, ADDR_COUNT, 32'd3, "os_cnt3");
    rd_chk(1, ADDR_COUNT, 32'd2, "os_cnt2");
    rd_chk(1, ADDR_COUNT, 32'd1, "os_cnt1");
    rd_chk(1, ADDR_COUNT, 32'd0, "os_cnt0");
    rd_chk(1, ADDR_STATUS, 32'h1, "os_exp");
    rd_chk(1, ADDR_CTRL, 32'h0, "os_en_clr");

    // LOAD beats tick, COUNT read-only, EN=0 freezes.
    wr(1, ADDR_STATUS, 32'h1);
    rd_chk(1, ADDR_STATUS, 32'h0, "clr_noexp");
    wr(1, ADDR_LOAD, 32'd10);
    wr(1, ADDR_CTRL, 32'h1);
    rd_chk(1, ADDR_COUNT, 32'd10, "run_cnt10");
    wr(1, ADDR_LOAD, 32'd7);
    rd_chk(1, ADDR_COUNT, 32'd7, "load_wins");
    rd_chk(1, ADDR_COUNT, 32'd6, "after_load");
    wr(1, ADDR_CTRL, 32'h0);
    wr(1, ADDR_COUNT, 32'h55);
    rd_chk(1, ADDR_COUNT, 32'd4, "count_ro");
    rd_chk(1, ADDR_COUNT, 32'd4, "frozen");

    // LOAD=0 with AUTO: expiry every tick; set beats clear; CTRL write beats EN clear.
    wr(1, ADDR_LOAD, 32'd0);
    wr(1, ADDR_CTRL, 32'h3);
    wr(1, ADDR_STATUS, 32'h1);
    rd_chk(1, ADDR_STATUS, 32'h1, "set_wins");
    wr(1, ADDR_CTRL, 32'h1);
    rd_chk(1, ADDR_CTRL, 32'h1, "ctrl_wr_wins");
    rd_chk(1, ADDR_CTRL, 32'h0, "oneshot_en_clr");
    rd_chk(1, ADDR_STATUS, 32'h1, "exp_still");
    wr(1, ADDR_STATUS, 32'h0);
    rd_chk(1, ADDR_STATUS, 32'h1, "w0_noeffect");
    wr(1, ADDR_STATUS, 32'h1);
    rd_chk(1, ADDR_STATUS, 32'h0, "w1c");

    // PRESCALE=4 auto-reload, irq behaviour.
    wr(4, ADDR_LOAD, 32'd2);
    wr(4, ADDR_CTRL, 32'h7);
    check_eq("irq_pre", {31'b0, irq4}, 32'd0);
    repeat (11) @(posedge clk);
    #1;
    rd_chk(4, ADDR_STATUS, 32'h0, "p4_noexp_11");
    check_eq("irq_edge", {31'b0, irq4}, IRQ_EXP);
    rd_chk(4, ADDR_STATUS, 32'h1, "p4_exp_12");
    rd_chk(4, ADDR_COUNT, 32'd2, "p4_reload");
    rd_chk(4, ADDR_COUNT, 32'd2, "p4_hold");
    @(posedge clk); #1;
    rd_chk(4, ADDR_COUNT, 32'd1, "p4_continue");
    rd_chk(4, ADDR_CTRL, CTRL7_RD, "p4_ctrl_rd");
    check_eq("irq_hold", {31'b0, irq4}, IRQ_EXP);
    wr(4, ADDR_CTRL, 32'h0);
    wr(4, ADDR_STATUS, 32'h1);
    check_eq("irq_clr", {31'b0, irq4}, 32'd0);
    rd_chk(4, ADDR_STATUS, 32'h0, "p4_clr");
    check_eq("irq1_idle", {31'b0, irq1}, 32'd0);

    // Reset during a pending read abandons it and clears everything.
    wr(1, ADDR_LOAD, 32'd9);
    wr(1, ADDR_CTRL, 32'h3);
    sel1 = 1'b1; we = 1'b0; addr = ADDR_COUNT;
    #3;
    rst_n = 1'b0;
    @(posedge clk); #1;
    sel1 = 1'b0;
    check_eq("rst_rvalid", {31'b0, rvalid1}, 32'd0);
    check_eq("rst_rdata", rdata1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_rvalid", {31'b0, rvalid1}, 32'd0);
    rd_chk(1, ADDR_CTRL, 32'h0, "rst_ctrl");
    rd_chk(1, ADDR_LOAD, 32'h0, "rst_load");
    rd_chk(1, ADDR_COUNT, 32'h0, "rst_count");
    rd_chk(1, ADDR_STATUS, 32'h0, "rst_status");

    // Back-to-back reads of all four offsets.
    wr(1, ADDR_LOAD, 32'h12);
    wr(1, ADDR_CTRL, 32'h2);
    rd_chk(1, ADDR_CTRL, 32'h2, "b2b_ctrl");
    rd_chk(1, ADDR_LOAD, 32'h12, "b2b_load");
    rd_chk(1, ADDR_COUNT, 32'h12, "b2b_count");
    rd_chk(1, ADDR_STATUS, 32'h0, "b2b_status");
    @(posedge clk); #1;
    check_eq("b2b_rvalid_end", {31'b0, rvalid1}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mmio_timer.md
MMIO_TIMER -- requirements
Module: mmio_timer

Interface
REQ-001 SHALL have parameter PRESCALE, default 1, meaning clk cycles per count tick (legal range 1..65535).
REQ-002 SHALL have parameter WIDTH, default 32, meaning counter and LOAD register width (8..32); narrower values zero-extend on rdata.
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port sel  input  1  bus access strobe for this responder.
REQ-006 SHALL have port we  input  1  write enable, qualified by sel.
REQ-007 SHALL have port addr  input  2  word offset: 0 CTRL, 1 LOAD, 2 COUNT, 3 STATUS.
REQ-008 SHALL have port wdata  input  32  write data.
REQ-009 SHALL have port rdata  output  32  registered read data.
REQ-010 SHALL have port rvalid  output  1  one-cycle pulse marking rdata valid.
REQ-011 SHALL have port irq  output  1  level interrupt request.

Function
REQ-012 Write (sel=1, we=1) SHALL take effect at the same clock edge; no wait states.
REQ-013 Read (sel=1, we=0) SHALL drive rdata and assert rvalid exactly one cycle later; rdata holds its value until the next read.
REQ-014 CTRL bits SHALL be: [0] EN, [1] AUTO reload, [2] IE; bits [31:3] read 0, writes ignored.
REQ-015 A LOAD write SHALL also load COUNT with wdata[WIDTH-1:0] and restart the prescaler.
REQ-016 COUNT SHALL be read-only; writes to it are ignored.
REQ-017 STATUS bit [0] SHALL be EXP (expired flag), write-1-to-clear; writing 0 has no effect.
REQ-018 While EN=1, the prescaler SHALL count 0..PRESCALE-1; each wrap is one tick.
REQ-019 On a tick with COUNT>0, COUNT SHALL decrement by 1.
REQ-020 On a tick with COUNT=0, EXP SHALL set.
REQ-021 On that expiry, if AUTO=1 COUNT SHALL reload from LOAD and EN stays 1; if AUTO=0, COUNT stays 0 and EN clears.
REQ-022 COUNT SHALL never wrap below 0.
REQ-023 EN=0 SHALL freeze COUNT and hold the prescaler at 0.
REQ-024 Expiry and EXP-clear in the same cycle: EXP SHALL end set (set wins).
REQ-025 Expiry and CTRL write in the same cycle: CTRL SHALL take the written value and EXP SHALL still set.
REQ-026 Tick and LOAD write in the same cycle: the LOAD value SHALL win, with no decrement and no expiry.
REQ-027 With LOAD=0 and AUTO=1, EXP SHALL set on every tick.

Reset
REQ-028 While reset=0, the block SHALL immediately clear CTRL, LOAD, COUNT, EXP, prescaler, rdata, rvalid and irq.
REQ-029 Reset asserted mid-count or mid-read SHALL abandon the operation; no rvalid after release.

Configuration
REQ-030 With macro MMIO_TIMER_IRQ_EN defined, irq SHALL equal EXP & IE, registered with no extra latency beyond EXP.
REQ-031 Without MMIO_TIMER_IRQ_EN, irq SHALL be tied 0, CTRL[2] SHALL read 0, and writes to it are ignored.

Structure
REQ-032 A shared package SHALL hold the register offsets (CTRL/LOAD/COUNT/STATUS) and the CTRL/STATUS bit-position constants.
REQ-033 The prescaler SHALL be a sub-module named mmio_prescaler with inputs clk, reset, en, restart and output tick.

Verification
REQ-034 PRESCALE=1: write LOAD=3, then CTRL=0x1 -> COUNT reads 3,2,1,0 on successive cycles; EXP=1 one tick after 0; EN reads 0.
REQ-035 PRESCALE=4, LOAD=2, CTRL=0x3 -> EXP sets 12 cycles after enable; COUNT reloads to 2; counting continues.
REQ-036 EXP=1: write STATUS=0x1 in the same cycle as the next expiry -> STATUS reads 0x1; a later clear without expiry -> reads 0x0.
REQ-037 MMIO_TIMER_IRQ_EN defined, CTRL=0x7, expiry -> irq=1 until EXP is cleared; without the macro -> irq stays 0 and CTRL reads 0x3.
REQ-038 Read COUNT with reset pulled low on the following cycle -> rvalid stays 0; all registers read 0 after release.
REQ-039 Back-to-back reads of addr 0,1,2,3 -> four consecutive rvalid pulses, each with data lagging its request by one cycle.
